// File: rtl/line_buf_ctrl.sv
// Sequencer for the cascaded line-buffer RAM chain: shared column address/write
// strobe, line and row counting, window-full tracking and frame-latched filter mode.
module line_buf_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned N_LINES  = 11,
    parameter int unsigned COL_W    = 13,
    parameter int unsigned ROW_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic             eol,
    input  logic             pix_valid,
    input  logic             filt_sel_in,
    output logic [COL_W-1:0] col_addr,
    output logic             wr_en,
    output logic             filt_sel,
    output logic [ROW_W-1:0] row,
    output logic [3:0]       lines_buffered,
    output logic             window_valid,
    output logic             out_valid,
    output logic             frame_done,
    output logic             overrun
);

    localparam logic [COL_W-1:0] HMax     = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0] RowLast  = ROW_W'(V_ACTIVE - 1);
    localparam logic [3:0]       LinesMax = 4'(N_LINES);

    typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [3:0]       lines_q, lines_d;
    logic             filt_sel_q, filt_sel_d;
    logic             overrun_q, overrun_d;
    logic             frame_done_q, frame_done_d;
    logic             active;
    logic             eol_counted;

    assign active      = (state_q != StIdle);
    assign wr_en       = pix_valid & active & (col_q < HMax) & ~sof;
    // A bare eol on an empty line is a blank line and must not advance anything.
    assign eol_counted = eol & active & ~sof & ((col_q != '0) | wr_en);

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        lines_d      = lines_q;
        filt_sel_d   = filt_sel_q;
        overrun_d    = overrun_q;
        frame_done_d = 1'b0;

        if (sof) begin
            state_d    = StFill;
            col_d      = '0;
            row_d      = '0;
            lines_d    = '0;
            overrun_d  = 1'b0;
            filt_sel_d = filt_sel_in;
        end else if (active) begin
            if (wr_en) begin
                col_d = col_q + COL_W'(1);
            end
            if (pix_valid && (col_q >= HMax)) begin
                overrun_d = 1'b1;
            end
            if (eol_counted) begin
                col_d = '0;
                if (lines_q < LinesMax) begin
                    lines_d = lines_q + 4'd1;
                end
                if ((state_q == StFill) && (lines_d == LinesMax)) begin
                    state_d = StRun;
                end
                // The last line of the frame wins over the FILL->RUN step.
                if (row_q == RowLast) begin
                    state_d      = StIdle;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            col_q        <= '0;
            row_q        <= '0;
            lines_q      <= '0;
            filt_sel_q   <= 1'b0;
            overrun_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            lines_q      <= lines_d;
            filt_sel_q   <= filt_sel_d;
            overrun_q    <= overrun_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign col_addr       = col_q;
    assign row            = row_q;
    assign lines_buffered = lines_q;
    assign filt_sel       = filt_sel_q;
    assign overrun        = overrun_q;
    assign frame_done     = frame_done_q;
    assign window_valid   = (state_q == StRun);
    assign out_valid      = wr_en & window_valid;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Scoreboard bench for line_buf_ctrl with a small 8x16 frame: stimulus queues
// expected writes and frame_done pulses, a negedge monitor pops and compares.
module tb_line_buf_ctrl;

    localparam int H = 8;
    localparam int V = 16;

    logic        clk = 1'b0;
    logic        rst, sof, eol, pix_valid, filt_sel_in;
    logic [12:0] col_addr;
    logic        wr_en, filt_sel, window_valid, out_valid, frame_done, overrun;
    logic [9:0]  row;
    logic [3:0]  lines_buffered;

    line_buf_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(V), .N_LINES(11), .COL_W(13), .ROW_W(10)
    ) dut (
        .clk(clk), .rst(rst), .sof(sof), .eol(eol), .pix_valid(pix_valid),
        .filt_sel_in(filt_sel_in), .col_addr(col_addr), .wr_en(wr_en),
        .filt_sel(filt_sel), .row(row), .lines_buffered(lines_buffered),
        .window_valid(window_valid), .out_valid(out_valid),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          c;
        logic [12:0] col;
        logic        ov;
    } wr_t;

    wr_t  wq[$];
    int   fq[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic fsi_cur = 1'b0;
    wr_t  e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write and every frame_done pulse must match a queued expectation.
    always @(negedge clk) begin
        while (wq.size() > 0 && wq[0].c < cyc) begin
            chk("wr_en_missing", 0, 1);
            void'(wq.pop_front());
        end
        if (wr_en) begin
            if (wq.size() == 0) begin
                chk("unexpected_wr_en", 1, 0);
            end else begin
                e = wq.pop_front();
                chk("wr_cycle", cyc, e.c);
                chk("col_addr", 32'(col_addr), 32'(e.col));
                chk("out_valid", 32'(out_valid), 32'(e.ov));
            end
        end
        while (fq.size() > 0 && fq[0] < cyc) begin
            chk("frame_done_missing", 0, 1);
            void'(fq.pop_front());
        end
        if (frame_done) begin
            if (fq.size() == 0) chk("unexpected_frame_done", 1, 0);
            else chk("frame_done_cycle", cyc, fq.pop_front());
        end
    end

    task automatic drive(input logic s, input logic eo, input logic p, input logic r,
                         input bit exp_wr, input int exp_col, input logic exp_ov);
        wr_t t;
        sof = s; eol = eo; pix_valid = p; rst = r; filt_sel_in = fsi_cur;
        if (exp_wr) begin
            t.c = cyc; t.col = 13'(exp_col); t.ov = exp_ov;
            wq.push_back(t);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic s, input logic eo, input logic p, input logic r,
                        input bit exp_wr, input int exp_col, input logic exp_ov);
        drive(s, eo, p, r, exp_wr, exp_col, exp_ov);
        tick();
    endtask

    // n pixels back to back, eol on the last; only the first H are written.
    task automatic line(input int n, input logic win);
        for (int i = 0; i < n; i++) begin
            step(1'b0, i == n - 1, 1'b1, 1'b0, i < H, (i < H) ? i : H, win);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        sof = 0; eol = 0; pix_valid = 0; filt_sel_in = 0; rst = 1;
        #1;
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("rst_col_addr", 32'(col_addr), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_row", 32'(row), 0);
        chk("rst_lines", 32'(lines_buffered), 0);
        chk("rst_filt_sel", 32'(filt_sel), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_window_valid", 32'(window_valid), 0);
        chk("rst_frame_done", 32'(frame_done), 0);

        // Idle: eol and pixels ignored.
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("idle_eol_row", 32'(row), 0);
        chk("idle_eol_lines", 32'(lines_buffered), 0);

        // One full line.
        step(1, 0, 0, 0, 0, 0, 0);
        chk("sof_lines", 32'(lines_buffered), 0);
        line(8, 0);
        chk("l1_col_addr", 32'(col_addr), 0);
        chk("l1_lines", 32'(lines_buffered), 1);
        chk("l1_window", 32'(window_valid), 0);
        chk("l1_row", 32'(row), 1);

        // Fill to 11 lines.
        for (int k = 2; k <= 10; k++) line(8, 0);
        chk("l10_lines", 32'(lines_buffered), 10);
        chk("l10_window", 32'(window_valid), 0);
        line(8, 0);
        chk("l11_window", 32'(window_valid), 1);
        chk("l11_lines", 32'(lines_buffered), 11);
        line(8, 1);
        chk("l12_lines_sat", 32'(lines_buffered), 11);
        chk("l12_row", 32'(row), 12);

        // Blank eol while running.
        step(0, 1, 0, 0, 0, 0, 0);
        chk("blank_row", 32'(row), 12);
        chk("blank_lines", 32'(lines_buffered), 11);

        // Overrun: 10 pixels in one line.
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 1, i, 1);
        drive(0, 0, 1, 0, 0, 0, 0);
        #1;
        chk("ovr_col_hold", 32'(col_addr), 8);
        chk("ovr_wr_en", 32'(wr_en), 0);
        tick();
        chk("ovr_flag", 32'(overrun), 1);
        step(0, 1, 1, 0, 0, 0, 0);
        chk("ovr_flag_eol", 32'(overrun), 1);
        chk("ovr_row", 32'(row), 13);
        chk("ovr_col_reset", 32'(col_addr), 0);
        line(8, 1);
        chk("ovr_sticky", 32'(overrun), 1);
        chk("l14_row", 32'(row), 14);
        line(8, 1);
        chk("l15_row", 32'(row), 15);

        // Last line of the frame.
        line(8, 1);
        fq.push_back(cyc);
        chk("fd_pulse", 32'(frame_done), 1);
        chk("fd_window", 32'(window_valid), 0);
        chk("fd_row_hold", 32'(row), 15);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("fd_one_cycle", 32'(frame_done), 0);
        chk("fd_overrun_kept", 32'(overrun), 1);

        // Filter-select latching and mid-frame sof abort.
        fsi_cur = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        chk("sof_overrun_clr", 32'(overrun), 0);
        chk("sof_filt_sel0", 32'(filt_sel), 0);
        chk("sof_row", 32'(row), 0);
        for (int k = 1; k <= 4; k++) line(8, 0);
        fsi_cur = 1;
        line(8, 0);
        line(8, 0);
        chk("midframe_filt_sel", 32'(filt_sel), 0);
        chk("l6_lines", 32'(lines_buffered), 6);
        drive(1, 0, 1, 0, 0, 0, 0);
        #1;
        chk("sof_pix_wr_en", 32'(wr_en), 0);
        tick();
        chk("abort_lines", 32'(lines_buffered), 0);
        chk("abort_window", 32'(window_valid), 0);
        chk("abort_row", 32'(row), 0);
        chk("abort_filt_sel1", 32'(filt_sel), 1);

        // Reset during pixel 4 of line 3.
        line(8, 0);
        line(8, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1, i, 0);
        drive(0, 0, 1, 1, 1, 3, 0);
        tick();
        chk("mrst_col_addr", 32'(col_addr), 0);
        chk("mrst_wr_en", 32'(wr_en), 0);
        chk("mrst_row", 32'(row), 0);
        chk("mrst_lines", 32'(lines_buffered), 0);
        chk("mrst_filt_sel", 32'(filt_sel), 0);
        chk("mrst_overrun", 32'(overrun), 0);
        chk("mrst_window", 32'(window_valid), 0);
        chk("mrst_frame_done", 32'(frame_done), 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        chk("wq_drained", wq.size(), 0);
        chk("fq_drained", fq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
